// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus bundle for axi4_lite_slave_regs: the five channels between
// one master and one register-bank slave. clk/rst are kept outside.
interface axi4_lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [2:0]              s_axi_awprot;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [2:0]              s_axi_arprot;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_rready
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_rready
    );
endinterface

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NB_REGS 32-bit read/write registers with byte
// strobes, a per-register write pulse, and independent read/write FSMs.
// Optional macro AXI4_LITE_SLAVE_SLVERR_EN: out-of-range accesses answer
// SLVERR instead of OKAY (out-of-range reads return zero in both builds).
module axi4_lite_slave_regs #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NB_REGS    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    axi4_lite_slave_regs_if.slave         bus,
    output logic [NB_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NB_REGS-1:0]            reg_wr_pulse
);
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_SLAVE_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    logic [DATA_WIDTH-1:0] regs [NB_REGS];

    // ---------------- write side ----------------
    w_state_t              w_state, w_state_next;
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  aw_hs, w_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic [NB_REGS-1:0]    wr_hit;
    logic                  wr_in_range;
    logic [1:0]            b_resp_q;
    logic [NB_REGS-1:0]    pulse_q;

    // Readys come only from state, held flags and rst (no valid->ready path).
    assign bus.s_axi_awready = !rst && (w_state == W_IDLE) && !aw_held;
    assign bus.s_axi_wready  = !rst && (w_state == W_IDLE) && !w_held;
    assign aw_hs  = bus.s_axi_awready && bus.s_axi_awvalid;
    assign w_hs   = bus.s_axi_wready && bus.s_axi_wvalid;
    // Commit as soon as both halves are available, whether held or arriving now.
    assign commit = !rst && (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_addr = aw_held ? aw_addr_q : bus.s_axi_awaddr;
    assign wr_data = w_held ? w_data_q : bus.s_axi_wdata;
    assign wr_strb = w_held ? w_strb_q : bus.s_axi_wstrb;
    assign wr_idx  = wr_addr[ADDR_WIDTH-1:2];
    assign wr_in_range = |wr_hit;

    // One-hot decode of the write target; no bit set means out of range.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NB_REGS; i++) begin
            wr_hit[i] = (wr_idx == IDX_W'(i));
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_next;
    end

    // Write FSM next state.
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE: if (commit) w_state_next = W_RESP;
            W_RESP: if (bus.s_axi_bready) w_state_next = W_IDLE;
        endcase
    end

    // Hold an AW or W beat that arrives ahead of its partner.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= bus.s_axi_awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= bus.s_axi_wdata;
                w_strb_q <= bus.s_axi_wstrb;
            end
        end
    end

    // Write response code and the one-cycle commit pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_resp_q <= RESP_OKAY;
            pulse_q  <= '0;
        end else begin
            pulse_q <= commit ? wr_hit : '0;
            if (commit) b_resp_q <= wr_in_range ? RESP_OKAY : RESP_OOR;
        end
    end

    // Register bank with byte-strobe merge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NB_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NB_REGS; i++) begin
                if (wr_hit[i]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign bus.s_axi_bvalid = !rst && (w_state == W_RESP);
    assign bus.s_axi_bresp  = rst ? RESP_OKAY : b_resp_q;
    assign reg_wr_pulse     = rst ? '0 : pulse_q;

    for (genvar g = 0; g < NB_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = rst ? '0 : regs[g];
    end

    // ---------------- read side ----------------
    r_state_t              r_state, r_state_next;
    logic                  ar_hs;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;

    assign bus.s_axi_arready = !rst && (r_state == R_IDLE);
    assign ar_hs  = bus.s_axi_arready && bus.s_axi_arvalid;
    assign rd_idx = bus.s_axi_araddr[ADDR_WIDTH-1:2];

    // Read mux; out-of-range indices select zero.
    always_comb begin
        rd_mux      = '0;
        rd_in_range = 1'b0;
        for (int i = 0; i < NB_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_mux      = regs[i];
                rd_in_range = 1'b1;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_next;
    end

    // Read FSM next state.
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE: if (ar_hs) r_state_next = R_RESP;
            R_RESP: if (bus.s_axi_rready) r_state_next = R_IDLE;
        endcase
    end

    // Capture read data at AR; sampling pre-edge regs gives the old value on a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= '0;
            r_resp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            r_data_q <= rd_mux;
            r_resp_q <= rd_in_range ? RESP_OKAY : RESP_OOR;
        end
    end

    assign bus.s_axi_rvalid = !rst && (r_state == R_RESP);
    assign bus.s_axi_rdata  = rst ? '0 : r_data_q;
    assign bus.s_axi_rresp  = rst ? RESP_OKAY : r_resp_q;

    // Protection bits and byte offsets carry no meaning for this bank.
    logic unused_bits;
    assign unused_bits = ^{bus.s_axi_awprot, bus.s_axi_arprot, wr_addr[1:0], bus.s_axi_araddr[1:0]};
endmodule
